// File: rtl/uart_buf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_buf_ctrl_pkg
// Purpose  : Shared constants and read-FSM state encoding for the UART echo
//            circular-buffer controller and the RAM it sequences.
// Revision : 1.0 - initial release
// ============================================================================
package uart_buf_ctrl_pkg;

    // Default RAM geometry, shared with the 512x8 dual-port RAM instance
    localparam int C_ADDR_W       = 9;
    localparam int C_BUSY_TIMEOUT = 16;
    localparam int C_DROP_W       = 8;

    // Buffer depth for a given address width
    function automatic int buf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Read-side FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t C_ST_IDLE      = 3'd0;
    localparam state_t C_ST_FETCH     = 3'd1;
    localparam state_t C_ST_SEND      = 3'd2;
    localparam state_t C_ST_WAIT_BUSY = 3'd3;
    localparam state_t C_ST_WAIT_DONE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_buf_ptr.sv
`default_nettype none
// ============================================================================
// Module   : uart_buf_ptr
// Purpose  : Write/read pointers, occupancy count, full/empty flags and
//            dropped-byte accounting for the UART echo circular buffer.
// Revision : 1.0 - initial release
// ============================================================================
module uart_buf_ptr
    import uart_buf_ctrl_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DROP_W = C_DROP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rx_rise,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [ADDR_W-1:0] o_wr_ptr,
    output logic [ADDR_W-1:0] o_rd_ptr,
    output logic [ADDR_W:0]   o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow,
    output logic [DROP_W-1:0] o_drop_cnt,
    output logic              o_wr_en
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              w_drop;

    // Flags and write strobe; count never exceeds DEPTH, so its MSB alone marks full
    always_comb begin
        o_full  = count_q[ADDR_W];
        o_empty = (count_q == '0);
        o_wr_en = i_rx_rise & ~o_full & ~i_flush;
        w_drop  = i_rx_rise &  o_full & ~i_flush;
    end

    // Next pointer/count/drop state; flush wins over any same-cycle write or pop
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (i_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            // Pointers wrap naturally at DEPTH through their width
            if (o_wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (i_pop)   rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{ADDR_W{1'b0}}, o_wr_en} - {{ADDR_W{1'b0}}, i_pop};
            if (w_drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    // Buffer bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_wr_ptr   = wr_ptr_q;
    assign o_rd_ptr   = rd_ptr_q;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: rtl/uart_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_buf_ctrl
// Purpose  : Circular-buffer controller between UART RX and TX in the echo
//            path: write-side edge detect plus fetch/send/wait read FSM.
// Revision : 1.0 - initial release
// ============================================================================
module uart_buf_ctrl
    import uart_buf_ctrl_pkg::*;
#(
    parameter int ADDR_W       = C_ADDR_W,
    parameter int BUSY_TIMEOUT = C_BUSY_TIMEOUT,
    parameter int DROP_W       = C_DROP_W
) (
    input  logic              ICE_CLK,
    input  logic              RST_N,
    input  logic              rx_dv,
    input  logic              flush,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_read_addr,
    output logic              tx_dv,
    input  logic              tx_done,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int             BT_W        = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [BT_W-1:0] c_busy_last = BT_W'(BUSY_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [BT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic            rx_dv_q, rx_dv_d;
    logic            w_rx_rise;

    // A long rx_dv high still counts as a single byte
    always_comb begin
        rx_dv_d   = rx_dv;
        w_rx_rise = rx_dv & ~rx_dv_q;
    end

    uart_buf_ptr #(
        .ADDR_W (ADDR_W),
        .DROP_W (DROP_W)
    ) u_ptr (
        .clk        (ICE_CLK),
        .rst_n      (RST_N),
        .i_rx_rise  (w_rx_rise),
        .i_pop      (tx_dv),
        .i_flush    (flush),
        .o_wr_ptr   (ram_write_addr),
        .o_rd_ptr   (ram_read_addr),
        .o_count    (count),
        .o_empty    (empty),
        .o_full     (full),
        .o_overflow (overflow),
        .o_drop_cnt (drop_cnt),
        .o_wr_en    (ram_write_en)
    );

    // State, busy-timeout counter and rx_dv history registers
    always_ff @(posedge ICE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= C_ST_IDLE;
            busy_cnt_q <= '0;
            rx_dv_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            rx_dv_q    <= rx_dv_d;
        end
    end

    // Next-state logic; flush aborts a pending fetch/send but lets a byte on the wire finish
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        case (state_q)
            C_ST_IDLE: begin
                if (!flush && !empty && tx_done) state_d = C_ST_FETCH;
            end
            C_ST_FETCH: begin
                state_d = flush ? C_ST_IDLE : C_ST_SEND;
            end
            C_ST_SEND: begin
                busy_cnt_d = '0;
                state_d    = flush ? C_ST_IDLE : C_ST_WAIT_BUSY;
            end
            C_ST_WAIT_BUSY: begin
                // A transmitter that never reports busy is treated as having sent the byte
                if (!tx_done) begin
                    state_d = C_ST_WAIT_DONE;
                end else if (busy_cnt_q == c_busy_last) begin
                    state_d = C_ST_IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q + 1'b1;
                end
            end
            C_ST_WAIT_DONE: begin
                if (tx_done) state_d = C_ST_IDLE;
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    // Send strobe straight from state so reset drops it immediately; also the buffer pop
    always_comb begin
        tx_dv = (state_q == C_ST_SEND) & ~flush;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_buf_ctrl
// Purpose  : Self-checking bench for uart_buf_ctrl: FIFO reference model with
//            a scoreboard of expected read addresses, directed corner cases
//            and randomized traffic against a modelled transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_buf_ctrl;

    localparam int ADDR_W       = 9;
    localparam int DEPTH        = 512;
    localparam int BUSY_TIMEOUT = 16;
    localparam int DROP_W       = 8;
    localparam int DROP_MAX     = 255;

    logic              ICE_CLK = 1'b0;
    logic              RST_N   = 1'b0;
    logic              rx_dv   = 1'b0;
    logic              flush   = 1'b0;
    logic              tx_done = 1'b1;
    logic [ADDR_W-1:0] ram_write_addr;
    logic              ram_write_en;
    logic [ADDR_W-1:0] ram_read_addr;
    logic              tx_dv;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    uart_buf_ctrl #(
        .ADDR_W       (ADDR_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .DROP_W       (DROP_W)
    ) dut (
        .ICE_CLK        (ICE_CLK),
        .RST_N          (RST_N),
        .rx_dv          (rx_dv),
        .flush          (flush),
        .ram_write_addr (ram_write_addr),
        .ram_write_en   (ram_write_en),
        .ram_read_addr  (ram_read_addr),
        .tx_dv          (tx_dv),
        .tx_done        (tx_done),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    always #5 ICE_CLK = ~ICE_CLK;

    int cyc = 0;
    always @(posedge ICE_CLK) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the buffer is a queue of the addresses each
    // accepted byte was written to; every send must read the oldest one.
    // ------------------------------------------------------------------
    int mq[$];
    int m_wr   = 0;
    bit m_ovf  = 1'b0;
    int m_drop = 0;
    bit m_prev = 1'b0;
    int txdv_cyc[$];

    initial forever begin
        @(negedge ICE_CLK);
        if (!RST_N) begin
            mq.delete();
            m_wr   = 0;
            m_ovf  = 1'b0;
            m_drop = 0;
            m_prev = 1'b0;
        end else begin
            bit rise;
            bit exp_we;
            check("count",    count,          mq.size());
            check("empty",    empty,          mq.size() == 0);
            check("full",     full,           mq.size() == DEPTH);
            check("overflow", overflow,       m_ovf);
            check("drop_cnt", drop_cnt,       m_drop);
            check("wr_addr",  ram_write_addr, m_wr);
            rise   = rx_dv && !m_prev;
            exp_we = rise && !flush && (mq.size() < DEPTH);
            check("write_en", ram_write_en, exp_we);
            if (tx_dv === 1'b1) begin
                if (txdv_cyc.size() > 0 && txdv_cyc[$] == cyc - 1)
                    check("tx_dv_pulse_width", tx_dv, 1'b0);
                txdv_cyc.push_back(cyc);
                if (flush) check("tx_dv_during_flush", tx_dv, 1'b0);
                if (mq.size() == 0) check("tx_dv_with_nothing_queued", tx_dv, 1'b0);
                else                check("read_addr", ram_read_addr, mq.pop_front());
            end
            if (flush) begin
                mq.delete();
                m_wr   = 0;
                m_ovf  = 1'b0;
                m_drop = 0;
            end else if (exp_we) begin
                mq.push_back(m_wr);
                m_wr = (m_wr + 1) % DEPTH;
            end else if (rise) begin
                m_ovf = 1'b1;
                if (m_drop < DROP_MAX) m_drop++;
            end
            m_prev = rx_dv;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter model: goes busy the cycle after tx_dv for a while.
    // ------------------------------------------------------------------
    bit tx_auto   = 1'b0;
    bit busy_rand = 1'b0;
    int busy_len  = 2;
    int tx_n      = 0;

    initial forever begin
        @(negedge ICE_CLK);
        if (tx_auto && tx_dv === 1'b1) begin
            tx_n = busy_rand ? int'($urandom_range(1, 24)) : busy_len;
            @(posedge ICE_CLK);
            #1 tx_done = 1'b0;
            repeat (tx_n) @(posedge ICE_CLK);
            #1 tx_done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ICE_CLK);
            #1;
        end
    endtask

    task automatic send_byte();
        rx_dv = 1'b1;
        tick();
        rx_dv = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        rx_dv = 1'b0;
        flush = 1'b0;
        tick(3);
        check("rst_count",    count,          0);
        check("rst_empty",    empty,          1);
        check("rst_full",     full,           0);
        check("rst_write_en", ram_write_en,   0);
        check("rst_tx_dv",    tx_dv,          0);
        check("rst_overflow", overflow,       0);
        check("rst_drop_cnt", drop_cnt,       0);
        check("rst_wr_addr",  ram_write_addr, 0);
        check("rst_rd_addr",  ram_read_addr,  0);
        RST_N = 1'b1;
        tick();
    endtask

    task automatic wait_tx(input int target, input int budget);
        int k = 0;
        while (txdv_cyc.size() < target && k < budget) begin
            tick();
            k++;
        end
        check("tx_dv_arrived_in_time", txdv_cyc.size() >= target, 1);
    endtask

    initial begin
        #3_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "watchdog expired");
    end

    int base;
    int t_w;
    int r;

    initial begin
        tick();
        // Single byte: tx_dv three cycles after the write, address 0
        do_reset();
        tick(5);
        base = txdv_cyc.size();
        t_w  = cyc;
        send_byte();
        wait_tx(base + 1, 50);
        if (txdv_cyc.size() > base) check("single_latency", txdv_cyc[base] - t_w, 3);
        tick(30);
        check("single_count_after", count, 0);
        check("single_empty_after", empty, 1);

        // Burst with a slow transmitter
        do_reset();
        busy_len = 100;
        tx_auto  = 1'b1;
        base     = txdv_cyc.size();
        repeat (5) send_byte();
        wait_tx(base + 5, 1000);
        for (int i = 1; i < 5; i++)
            if (txdv_cyc.size() > base + i)
                check("burst_gap_at_least_100", (txdv_cyc[base+i] - txdv_cyc[base+i-1]) >= 100, 1);
        tick(150);
        check("burst_send_count", txdv_cyc.size() - base, 5);
        tx_auto = 1'b0;

        // Fill to full with a stalled transmitter, overflow, then drain with wrap
        do_reset();
        tx_done = 1'b0;
        base    = txdv_cyc.size();
        repeat (DEPTH + 3) send_byte();
        check("wrap_count_full", count,          DEPTH);
        check("wrap_full_flag",  full,           1);
        check("wrap_wr_addr",    ram_write_addr, 0);
        check("wrap_overflow",   overflow,       1);
        check("wrap_drop_cnt",   drop_cnt,       3);
        check("wrap_no_send",    txdv_cyc.size() - base, 0);
        busy_len = 2;
        tx_auto  = 1'b1;
        tx_done  = 1'b1;
        wait_tx(base + DEPTH, 20000);
        tick(10);
        check("wrap_drained_count", count,         0);
        check("wrap_rd_addr",       ram_read_addr, 0);
        tx_auto = 1'b0;

        // Write in the same cycle as a SEND pop
        do_reset();
        tx_done = 1'b0;
        repeat (4) send_byte();
        tick(2);
        tx_done = 1'b1;
        tick();
        tick();
        rx_dv = 1'b1;
        @(negedge ICE_CLK);
        check("simul_tx_dv",    tx_dv,        1);
        check("simul_write_en", ram_write_en, 1);
        @(posedge ICE_CLK);
        #1 rx_dv = 1'b0;
        check("simul_count",   count,          4);
        check("simul_wr_addr", ram_write_addr, 5);
        check("simul_rd_addr", ram_read_addr,  1);
        tick(150);

        // Flush during FETCH
        do_reset();
        tx_done = 1'b0;
        repeat (7) send_byte();
        check("flush_pre_count", count, 7);
        tx_done = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_fetch_count", count, 0);
        check("flush_fetch_empty", empty, 1);
        base = txdv_cyc.size();
        tick(40);
        check("flush_fetch_no_send", txdv_cyc.size() - base, 0);

        // Flush during SEND suppresses the strobe
        do_reset();
        tx_done = 1'b0;
        repeat (2) send_byte();
        tx_done = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        @(negedge ICE_CLK);
        check("flush_send_tx_dv", tx_dv, 0);
        @(posedge ICE_CLK);
        #1 flush = 1'b0;
        base = txdv_cyc.size();
        tick(40);
        check("flush_send_no_send", txdv_cyc.size() - base, 0);

        // Flush during WAIT_DONE: in-flight byte completes, nothing more sent
        do_reset();
        busy_len = 30;
        tx_auto  = 1'b1;
        base     = txdv_cyc.size();
        repeat (3) send_byte();
        wait_tx(base + 1, 50);
        tick(10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_wait_count", count, 0);
        tick(100);
        check("flush_wait_sends", txdv_cyc.size() - base, 1);
        send_byte();
        wait_tx(base + 2, 60);
        tick(40);
        tx_auto = 1'b0;

        // Transmitter never goes busy: timeout then next byte
        do_reset();
        tx_done = 1'b1;
        base    = txdv_cyc.size();
        send_byte();
        send_byte();
        wait_tx(base + 2, 100);
        if (txdv_cyc.size() > base + 1)
            check("stuck_gap", txdv_cyc[base+1] - txdv_cyc[base], BUSY_TIMEOUT + 3);
        tick(30);

        // Asynchronous reset while tx_dv is high
        send_byte();
        for (int k = 0; k < 100; k++) begin
            @(negedge ICE_CLK);
            if (tx_dv === 1'b1) break;
        end
        check("async_pre_tx_dv", tx_dv, 1);
        #1 RST_N = 1'b0;
        #1;
        check("async_rst_tx_dv", tx_dv, 0);
        check("async_rst_count", count, 0);
        check("async_rst_empty", empty, 1);
        tick(2);
        RST_N = 1'b1;
        tick();

        // Randomized traffic with a randomly slow transmitter and sporadic flushes
        do_reset();
        busy_rand = 1'b1;
        tx_auto   = 1'b1;
        for (int it = 0; it < 2500; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                rx_dv = 1'b1;
                tick(int'($urandom_range(1, 3)));
                rx_dv = 1'b0;
                tick(int'($urandom_range(1, 3)));
            end else if (r < 58) begin
                flush = 1'b1;
                rx_dv = 1'($urandom_range(0, 1));
                tick();
                flush = 1'b0;
                rx_dv = 1'b0;
                tick();
            end else begin
                tick(int'($urandom_range(1, 6)));
            end
        end
        for (int k = 0; k < 30000 && mq.size() > 0; k++) tick();
        tick(50);
        check("random_drained_count", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_buf_ctrl.md
Name: uart_buf_ctrl

Overview:
Circular-buffer controller that sequences the 512x8 dual-port RAM between the UART receiver and the UART transmitter in the echo path. It owns the write and read pointers, occupancy count and full/empty flags, and runs a fetch/send/wait FSM that hands one byte at a time to the transmitter. Overflow, wrap-around, flush and transmitter-stall cases are resolved here, so the top level only wires it up.

Parameters:
ADDR_W, 9, RAM address width; buffer depth DEPTH = 2**ADDR_W (512).
BUSY_TIMEOUT, 16, max cycles to wait for tx_done to fall after a tx_dv pulse before giving up.
DROP_W, 8, width of the saturating dropped-byte counter.

Ports:
ICE_CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
rx_dv  in  1  receiver data-valid; one byte per rising edge of this signal
flush  in  1  synchronous buffer clear, 1-cycle pulse or level
ram_write_addr  out  ADDR_W  RAM write address (= wr_ptr)
ram_write_en  out  1  RAM write strobe
ram_read_addr  out  ADDR_W  RAM read address (= rd_ptr, registered)
tx_dv  out  1  one-cycle send strobe to transmitter
tx_done  in  1  transmitter idle (high) / busy (low)
count  out  ADDR_W+1  bytes stored, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  sticky: a byte was dropped while full
drop_cnt  out  DROP_W  dropped bytes, saturates at all-ones

Behaviour:
- Reset (RST_N low, async): wr_ptr = rd_ptr = 0, count = 0, state IDLE, tx_dv = 0, overflow = 0, drop_cnt = 0, rx_dv_q = 0. Outputs: empty = 1, full = 0, ram_write_en = 0.
- Write side: rx_rise = rx_dv & ~rx_dv_q, where rx_dv_q is rx_dv registered.
- A multi-cycle rx_dv high counts as one byte.
- ram_write_en = rx_rise & ~full & ~flush (combinational). Write lands at wr_ptr. wr_ptr increments on the next edge and wraps DEPTH-1 -> 0.
- rx_rise while full: no write. overflow set, drop_cnt + 1 (saturating).
- Read FSM:
  - IDLE: ~empty & tx_done -> FETCH.
  - FETCH: 1 cycle for the synchronous RAM read of rd_ptr -> SEND.
  - SEND: tx_dv = 1 for exactly this cycle; ram_dout valid this cycle. rd_ptr + 1 (wraps), count - 1 -> WAIT_BUSY.
  - WAIT_BUSY: tx_done == 0 -> WAIT_DONE. After BUSY_TIMEOUT cycles still high -> IDLE (byte treated as sent).
  - WAIT_DONE: tx_done == 1 -> IDLE.
- Transmitter must latch tx_byte on tx_dv; ram_dout may change the next cycle.
- Latency: byte written into an empty buffer with an idle transmitter -> tx_dv 3 cycles after ram_write_en (IDLE sees ~empty at +1, FETCH +2, SEND +3).
- Simultaneous write and SEND pop: count unchanged, both pointers advance.
- Write while full and SEND in the same cycle: full is evaluated before the pop, so the byte is dropped.
- flush:
  - Next edge: wr_ptr = rd_ptr = 0, count = 0, overflow = 0, drop_cnt = 0.
  - If state is FETCH or SEND -> IDLE, with tx_dv suppressed in that cycle.
  - If state is WAIT_BUSY or WAIT_DONE, the wait continues, so the in-flight byte finishes on the wire.
  - flush has priority over a same-cycle write (write discarded).
- Mid-operation reset: all state cleared immediately. tx_dv drops asynchronously.
- Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count == DEPTH when full with wr_ptr == rd_ptr.

Decomposition:
- Shared package: FSM state encoding (IDLE, FETCH, SEND, WAIT_BUSY, WAIT_DONE) and the default ADDR_W / depth constants shared with the RAM instance.
- Sub-module: uart_buf_ptr (pointer, count, full/empty and drop accounting) with the FSM kept in uart_buf_ctrl. Splitting is optional but natural.

Test Plan:
- Single byte: reset, tx_done = 1, rx_dv pulse at cycle 10 -> ram_write_en at 10 with addr 0; tx_dv at cycle 13 with ram_read_addr 0; count back to 0, empty = 1.
- Burst, slow transmitter: 5 rx_dv pulses, tx_done low for 100 cycles after each tx_dv -> exactly 5 tx_dv pulses reading addrs 0..4 in order, each separated by ≥ 100 cycles.
- Wrap and full: tx_done held low, 512 writes -> full = 1, count = 512, wr_ptr = 0. 3 more writes -> overflow = 1, drop_cnt = 3. Release tx_done -> 512 sends, reading addrs 0..511 with rd_ptr wrapping to 0.
- Simultaneous: with count = 4 and state SEND, assert rx_rise in the same cycle -> count stays 4, both pointers advance by 1.
- Flush: count = 7, flush pulse during FETCH -> next cycle count = 0, state IDLE, no tx_dv; flush during WAIT_DONE -> in-flight byte completes, then no further tx_dv.
- Stuck transmitter: tx_done held at 1 forever after a send -> FSM returns to IDLE after 16 cycles and the next byte is sent.
